conv_window_scheduler: RTL and testbench
========================================

Name: conv_window_scheduler

Overview:
- Frame-level sequencer for the PE convolution datapath.
- Accepts a raster pixel stream and tracks the pixel position, which also drives the line buffer's write strobe.
- After each pixel that completes a valid kernel_size x kernel_size window (stride 1, no padding), it fires one enable_read to the PE, waits for conv_done, and forwards the result on a valid/ready output.
- Sits between the pixel source / line buffer and the PE plus result sink.

Parameters:
- kernel_size, 2, window edge length (K); must be at least 2 and at most min(data_width, data_height).
- data_width, 4, pixels per image row (W).
- data_height, 4, rows per frame (H).
- point_width, 8, bit width of one pixel and of one result.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  begin a frame; sampled only in IDLE.
- pix_valid  in  1  source has a pixel.
- pix_ready  out  1  scheduler accepts the pixel; also serves as the line-buffer write strobe when ANDed with pix_valid.
- pe_enable_read  out  1  one-cycle pulse to the PE: window is valid.
- pe_conv_done  in  1  PE result valid.
- pe_conv_result  in  point_width  PE result.
- res_valid  out  1  result available.
- res_data  out  point_width  registered result.
- res_ready  in  1  sink accepts the result.
- busy  out  1  high whenever state is not IDLE.
- frame_done  out  1  one-cycle pulse after the last result is consumed.
- col_idx  out  clog2(W)  column of the next pixel to accept.
- row_idx  out  clog2(H)  row of the next pixel to accept.
- err_spurious_done  out  1  sticky; set when pe_conv_done is seen outside WAIT; cleared by reset or start.

Behaviour:
- Reset values: state IDLE; all outputs 0; col/row counters 0; result register 0.
- All outputs are registered, or decoded directly from the state register with no input-to-output combinational path.

FSM states and transitions:
- IDLE: on start, clear counters and err, go to ACCEPT.
- ACCEPT: pix_ready=1. On a pix_valid handshake:
  - Advance the counters. col wraps W-1 -> 0 and increments row at the same time.
  - If the accepted pixel has row >= K-1 and col >= K-1, go to ISSUE.
  - Else, if it was the last pixel (row H-1, col W-1), go to DONE. This is unreachable for legal K but is still required.
  - Else stay in ACCEPT.
- ISSUE: pe_enable_read=1 for exactly one cycle; the line buffer has had one cycle to update. Go to WAIT.
- WAIT: pix_ready=0, which back-pressures the source. On pe_conv_done, register pe_conv_result into res_data and go to OUT. No timeout.
- OUT: res_valid=1, res_data held stable until res_ready.
  - On handshake: if the window just emitted was the last in the frame, go to DONE; else go to ACCEPT.
- DONE: frame_done=1 for one cycle, then IDLE.

Throughput, latency and counts:
- Results per frame = (W-K+1)*(H-K+1), which is 9 at defaults. Results are emitted in raster order of window bottom-right corner.
- Pixel handshake at cycle t gives pe_enable_read at t+1.
- With PE latency L cycles from enable_read to conv_done, res_valid rises at t+2+L.
- Minimum per-window cost is 4 cycles (ACCEPT, ISSUE, WAIT with L=1, OUT with res_ready already high).
- Pixels that complete no window cost 1 cycle each.

Boundary conditions:
- start while busy: ignored.
- pe_conv_done in the same cycle as the ISSUE pulse: ignored and flags err. A legal PE has L >= 1.
- res_ready held low: OUT holds indefinitely; pix_ready stays 0.
- Reset asserted mid-frame: immediate return to IDLE; all outputs 0 in the same cycle, asynchronously.
- pix_valid while not in ACCEPT: not consumed; counters unchanged.

Decomposition:
- Shared package conv_pkg holds:
  - state encoding constants (IDLE, ACCEPT, ISSUE, WAIT, OUT, DONE; 3-bit);
  - the clog2 function;
  - the derived constants OUT_COLS = W-K+1, OUT_ROWS = H-K+1, N_RESULTS.
- One natural sub-module, raster_counter: a col/row counter with wrap, plus window_valid and last_pixel flags, parameterised by W, H and K. It is reused by the line buffer.

Test Plan:
- Defaults, start, 16 pixels of value 1..16 with pix_valid held high, PE model with L=1 returning the sum of the 2x2 window, res_ready=1 -> results 14,18,22,30,34,38,46,50,54 in order, frame_done once, busy back to 0.
- Result-count check: the same frame gives exactly 9 pe_enable_read pulses. The first pulse comes one cycle after the handshake of pixel index 5 (row 1, col 1); pixels 0-4 produce none.
- res_ready held low for 10 cycles on the first result -> res_valid and res_data (14) stable throughout, pix_ready=0, no new pe_enable_read.
- PE latency L=5 with pix_valid toggling every other cycle -> same 9 results; no pixel is lost or duplicated; the col_idx/row_idx sequence is monotonic raster order.
- Reset pulsed while in WAIT of the 4th window -> all outputs 0 immediately. A subsequent start gives a full correct frame of 9 results.
- pe_conv_done pulsed while in IDLE, and a second start issued mid-frame -> err_spurious_done=1 and the mid-frame start has no effect. The next start in IDLE clears err.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window scheduler and line buffer:
// FSM state encodings, clog2 helper and derived window-count constants.
package conv_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ACCEPT = 3'd1;
    localparam logic [2:0] ISSUE  = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] OUT    = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    localparam int unsigned DEF_KERNEL = 2;
    localparam int unsigned DEF_WIDTH  = 4;
    localparam int unsigned DEF_HEIGHT = 4;

    localparam int unsigned OUT_COLS  = DEF_WIDTH - DEF_KERNEL + 1;
    localparam int unsigned OUT_ROWS  = DEF_HEIGHT - DEF_KERNEL + 1;
    localparam int unsigned N_RESULTS = OUT_COLS * OUT_ROWS;

    // Never returns less than 1 so that index ports always have a legal width.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) bits = i + 1;
        end
        return bits;
    endfunction

    function automatic int unsigned out_count(input int unsigned size, input int unsigned kernel);
        return size - kernel + 1;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order column/row counter with window-valid and last-pixel flags.
// Flags describe the position currently held, i.e. the next pixel to accept.
module raster_counter
    import conv_pkg::*;
#(
    parameter int unsigned kernel_size = 2,
    parameter int unsigned data_width  = 4,
    parameter int unsigned data_height = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           advance,
    output logic [clog2(data_width)-1:0]   col,
    output logic [clog2(data_height)-1:0]  row,
    output logic                           window_valid,
    output logic                           last_pixel
);

    localparam int unsigned CB = clog2(data_width);
    localparam int unsigned RB = clog2(data_height);

    localparam logic [CB-1:0] COL_LAST = CB'(data_width - 1);
    localparam logic [RB-1:0] ROW_LAST = RB'(data_height - 1);
    localparam logic [CB-1:0] COL_WIN  = CB'(kernel_size - 1);
    localparam logic [RB-1:0] ROW_WIN  = RB'(kernel_size - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RB'(1);
            end else begin
                col <= col + CB'(1);
            end
        end
    end

    assign window_valid = (col >= COL_WIN) && (row >= ROW_WIN);
    assign last_pixel   = (col == COL_LAST) && (row == ROW_LAST);

endmodule

// File: rtl/conv_window_scheduler.sv
// Frame sequencer: accepts raster pixels, fires one PE read per completed
// KxK window, waits for the PE result and forwards it on a valid/ready port.
module conv_window_scheduler
    import conv_pkg::*;
#(
    parameter int unsigned kernel_size = 2,
    parameter int unsigned data_width  = 4,
    parameter int unsigned data_height = 4,
    parameter int unsigned point_width = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           pix_valid,
    output logic                           pix_ready,
    output logic                           pe_enable_read,
    input  logic                           pe_conv_done,
    input  logic [point_width-1:0]         pe_conv_result,
    output logic                           res_valid,
    output logic [point_width-1:0]         res_data,
    input  logic                           res_ready,
    output logic                           busy,
    output logic                           frame_done,
    output logic [clog2(data_width)-1:0]   col_idx,
    output logic [clog2(data_height)-1:0]  row_idx,
    output logic                           err_spurious_done
);

    logic [2:0] state;
    logic       last_win;
    logic       win_valid;
    logic       last_pix;
    logic       pix_hs;
    logic       clear;

    assign pix_hs = (state == ACCEPT) && pix_valid;
    assign clear  = (state == IDLE) && start;

    raster_counter #(
        .kernel_size (kernel_size),
        .data_width  (data_width),
        .data_height (data_height)
    ) u_raster (
        .clock        (clock),
        .reset        (reset),
        .clear        (clear),
        .advance      (pix_hs),
        .col          (col_idx),
        .row          (row_idx),
        .window_valid (win_valid),
        .last_pixel   (last_pix)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            last_win          <= 1'b0;
            res_data          <= '0;
            err_spurious_done <= 1'b0;
        end else begin
            if (clear)
                err_spurious_done <= 1'b0;
            else if (pe_conv_done && (state != WAIT))
                err_spurious_done <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) state <= ACCEPT;
                end
                ACCEPT: begin
                    if (pix_valid) begin
                        // The last window is the one whose corner is the frame's final pixel.
                        if (win_valid) begin
                            state    <= ISSUE;
                            last_win <= last_pix;
                        end else if (last_pix) begin
                            state <= DONE;
                        end
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (pe_conv_done) begin
                        res_data <= pe_conv_result;
                        state    <= OUT;
                    end
                end
                OUT: begin
                    if (res_ready) state <= last_win ? DONE : ACCEPT;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign pix_ready      = (state == ACCEPT);
    assign pe_enable_read = (state == ISSUE);
    assign res_valid      = (state == OUT);
    assign frame_done     = (state == DONE);
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Randomized self-checking bench for conv_window_scheduler with a behavioural
// PE / line-buffer model and a window-sum reference queue.
module tb_conv_window_scheduler;

    localparam int K    = 2;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int PW   = 8;
    localparam int NPIX = W * H;
    localparam int NRES = (W - K + 1) * (H - K + 1);

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          pix_valid;
    logic          pix_ready;
    logic          pe_enable_read;
    logic          pe_conv_done;
    logic [PW-1:0] pe_conv_result;
    logic          res_valid;
    logic [PW-1:0] res_data;
    logic          res_ready;
    logic          busy;
    logic          frame_done;
    logic [1:0]    col_idx;
    logic [1:0]    row_idx;
    logic          err;

    logic          pe_fire = 1'b0;
    logic          spur    = 1'b0;
    logic [PW-1:0] pe_res  = '0;

    assign pe_conv_done   = pe_fire | spur;
    assign pe_conv_result = pe_res;

    always #5 clock = ~clock;

    conv_window_scheduler #(
        .kernel_size (K),
        .data_width  (W),
        .data_height (H),
        .point_width (PW)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .pix_valid         (pix_valid),
        .pix_ready         (pix_ready),
        .pe_enable_read    (pe_enable_read),
        .pe_conv_done      (pe_conv_done),
        .pe_conv_result    (pe_conv_result),
        .res_valid         (res_valid),
        .res_data          (res_data),
        .res_ready         (res_ready),
        .busy              (busy),
        .frame_done        (frame_done),
        .col_idx           (col_idx),
        .row_idx           (row_idx),
        .err_spurious_done (err)
    );

    int tests = 0;
    int fails = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    int pix_vals[NPIX];
    int exp_q[$];
    int gcyc = 0;
    int hs_cnt, en_cnt, res_cnt, fd_cnt;
    int last_hs_cyc, last_en_cyc;
    int pe_wait = 0;
    int pe_lat  = 1;
    int pe_val  = 0;
    bit mon_en  = 1'b0;
    bit prev_rv = 1'b0;

    // Sum of the KxK window whose bottom-right corner is raster index idx.
    function automatic int window_sum(input int idx);
        int r, c, s;
        r = idx / W;
        c = idx % W;
        s = 0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                s += pix_vals[(r - i) * W + (c - j)];
        return s & 255;
    endfunction

    always @(posedge clock) gcyc++;

    // PE model: result appears pe_lat cycles after the enable_read cycle.
    always @(posedge clock) begin
        #1;
        pe_fire = 1'b0;
        pe_res  = PW'($urandom);
        if (pe_wait > 0) begin
            pe_wait--;
            if (pe_wait == 0) begin
                pe_fire = 1'b1;
                pe_res  = PW'(pe_val);
            end
        end
    end

    always @(negedge clock) begin
        if (mon_en && !reset) begin
            if (pix_valid && pix_ready) begin
                check_eq("col_idx", col_idx, hs_cnt % W);
                check_eq("row_idx", row_idx, hs_cnt / W);
                hs_cnt++;
                last_hs_cyc = gcyc;
            end
            if (pe_enable_read) begin
                en_cnt++;
                check_eq("en_after_hs", gcyc, last_hs_cyc + 1);
                if (en_cnt == 1) check_eq("first_en_pixel", hs_cnt, (K - 1) * W + K);
                pe_val      = window_sum(hs_cnt - 1);
                pe_wait     = pe_lat;
                last_en_cyc = gcyc;
            end
            if (res_valid && !prev_rv) check_eq("res_latency", gcyc, last_en_cyc + pe_lat + 1);
            prev_rv = res_valid;
            if (res_valid && res_ready) begin
                res_cnt++;
                if (exp_q.size() == 0) check_eq("res_overflow", res_cnt, NRES);
                else check_eq("res_data", res_data, exp_q.pop_front());
            end
            if (frame_done) fd_cnt++;
        end
    end

    task automatic run_frame(input int lat, input int vmode, input int rmode, input bit seq,
                             input bit stall, input int abort_en, input bit mid_start,
                             input bit issue_spur);
        int n;
        bit stall_done;
        for (int i = 0; i < NPIX; i++) pix_vals[i] = seq ? i + 1 : int'($urandom_range(0, 255));
        exp_q.delete();
        for (int r = K - 1; r < H; r++)
            for (int c = K - 1; c < W; c++)
                exp_q.push_back(window_sum(r * W + c));
        hs_cnt = 0; en_cnt = 0; res_cnt = 0; fd_cnt = 0; prev_rv = 1'b0;
        pe_lat = lat; pe_wait = 0; last_hs_cyc = -10; last_en_cyc = -10;
        mon_en = 1'b1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check_eq("busy_start", busy, 1);
        check_eq("err_cleared", err, 0);
        check_eq("col_start", col_idx, 0);
        check_eq("row_start", row_idx, 0);

        n = 0;
        stall_done = 1'b0;
        while (fd_cnt == 0 && n < 3000) begin
            case (vmode)
                0:       pix_valid = 1'b1;
                1:       pix_valid = n[0];
                default: pix_valid = 1'($urandom_range(0, 1));
            endcase
            res_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            spur  = issue_spur && pe_enable_read;
            start = mid_start && (n == 4);
            if (stall && !stall_done && res_valid) begin
                res_ready = 1'b0;
                repeat (10) begin
                    @(negedge clock);
                    check_eq("stall_valid", res_valid, 1);
                    check_eq("stall_data", res_data, 14);
                    check_eq("stall_pix_ready", pix_ready, 0);
                    check_eq("stall_no_en", pe_enable_read, 0);
                    @(posedge clock); #1;
                end
                stall_done = 1'b1;
                res_ready  = 1'b1;
            end
            if (abort_en > 0 && en_cnt == abort_en && busy && !pe_enable_read) begin
                check_eq("pre_abort_wait", {pix_ready, res_valid, busy}, 3'b001);
                #2;
                reset = 1'b1;
                #1;
                check_eq("abort_busy", busy, 0);
                check_eq("abort_pix_ready", pix_ready, 0);
                check_eq("abort_en", pe_enable_read, 0);
                check_eq("abort_res_valid", res_valid, 0);
                check_eq("abort_res_data", res_data, 0);
                check_eq("abort_frame_done", frame_done, 0);
                check_eq("abort_idx", {col_idx, row_idx}, 0);
                pe_wait = 0;
                mon_en  = 1'b0;
                pix_valid = 1'b0;
                start = 1'b0;
                @(posedge clock); #1;
                reset = 1'b0;
                return;
            end
            @(posedge clock); #1;
            n++;
        end
        check_eq("frame_timeout", fd_cnt > 0, 1);
        check_eq("busy_end", busy, 0);
        pix_valid = 1'b0;
        start = 1'b0;
        spur  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("frame_done_count", fd_cnt, 1);
        check_eq("result_count", res_cnt, NRES);
        check_eq("enable_count", en_cnt, NRES);
        check_eq("pixel_count", hs_cnt, NPIX);
        check_eq("results_left", exp_q.size(), 0);
        mon_en = 1'b0;
        res_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pix_valid = 1'b0; res_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_pix_ready", pix_ready, 0);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_res_data", res_data, 0);
        check_eq("rst_err", err, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // sequential pixels 1..16, L=1, sink always ready
        run_frame(1, 0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        // first result stalled for 10 cycles
        run_frame(1, 0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        // slow PE, toggling source
        run_frame(5, 1, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        // reset while waiting on the 4th window, then a full frame
        run_frame(8, 0, 0, 1'b1, 1'b0, 4, 1'b0, 1'b0);
        run_frame(1, 0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0);

        // spurious done in IDLE
        spur = 1'b1;
        @(posedge clock); #1;
        spur = 1'b0;
        check_eq("err_idle_spur", err, 1);
        check_eq("idle_spur_busy", busy, 0);
        // mid-frame start plus done coinciding with the ISSUE pulse
        run_frame(2, 0, 0, 1'b1, 1'b0, 0, 1'b1, 1'b1);
        check_eq("err_issue_spur", err, 1);

        for (int f = 0; f < 6; f++)
            run_frame(int'($urandom_range(1, 5)), 2, 1, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
